// File: rtl/i_cache_fill_pkg.sv
// Shared types and constants for the instruction-cache refill engine.
package i_fill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DONE,
    ERR
  } fill_state_t;

  localparam int unsigned      I_ADDR_W     = 20;
  localparam int unsigned      I_DATA_W     = 32;
  localparam int unsigned      I_BURST_LEN  = 8;
  localparam int unsigned      I_TIMEOUT    = 255;
  // Legal instruction window; also used by the i_cache range check.
  localparam logic [19:0]      I_BASE_ADDR  = 20'h10000;
  localparam logic [19:0]      I_LIMIT_ADDR = 20'h101FF;

endpackage

// File: rtl/i_cache_fill_if.sv
// Miss, memory-request and cache-write signals of the refill engine.
interface i_cache_fill_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
);
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              fill_busy;
  logic              fill_done;
  logic              fill_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              cache_wr_en;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wr_ins;

  // Refill engine side.
  modport master (
    input  miss_req, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    output fill_busy, fill_done, fill_err, mem_req, mem_addr,
           cache_wr_en, cache_addr, cache_wr_ins
  );

  // Fetch / memory / cache side.
  modport slave (
    output miss_req, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  fill_busy, fill_done, fill_err, mem_req, mem_addr,
           cache_wr_en, cache_addr, cache_wr_ins
  );
endinterface

// File: rtl/i_cache_fill_timeout_ctr.sv
// Idle-cycle counter between data beats; saturates at Timeout and flags expiry.
module ifill_timeout_ctr #(
  parameter int unsigned Width   = 8,
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam logic [Width-1:0] Limit = Width'(Timeout);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Limit);

  // Clear wins over count; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/i_cache_fill.sv
// Instruction-cache refill engine: burst request, beat-by-beat cache writes, done/error pulses.
module i_cache_fill
  import i_fill_pkg::*;
#(
  parameter int unsigned       ADDR_W     = I_ADDR_W,
  parameter int unsigned       DATA_W     = I_DATA_W,
  parameter int unsigned       BURST_LEN  = I_BURST_LEN,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = I_BASE_ADDR,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = I_LIMIT_ADDR,
  parameter int unsigned       TIMEOUT    = I_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  i_cache_fill_if.master bus
);
  // One extra bit so the count can reach BURST_LEN and mark "all beats taken".
  localparam int unsigned       CntW      = $clog2(BURST_LEN) + 1;
  localparam logic [CntW-1:0]   BurstCnt  = CntW'(BURST_LEN);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(BURST_LEN - 1);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wins_q, wins_d;
  logic              tmr_expired;
  logic              in_range;

  assign in_range = (bus.miss_addr >= BASE_ADDR) && (bus.miss_addr <= LIMIT_ADDR);

  // Timer only runs in DATA and restarts on every returned beat.
  ifill_timeout_ctr #(
    .Width  (8),
    .Timeout(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    ((state_q != DATA) || bus.mem_rvalid),
    .en_i     (state_q == DATA),
    .expired_o(tmr_expired)
  );

  // Next-state, beat counter and write-port staging.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wins_d  = wins_q;
    unique case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          if (in_range) begin
            base_d  = bus.miss_addr & AlignMask;
            state_d = REQ;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // Finish only once the last write has actually been presented.
        if (wr_en_q && (cnt_q == BurstCnt)) begin
          state_d = DONE;
        end else if (tmr_expired) begin
          state_d = ERR;
        end else if (bus.mem_rvalid && (cnt_q < BurstCnt)) begin
          wr_en_d = 1'b1;
          waddr_d = base_q + ADDR_W'(cnt_q);
          wins_d  = bus.mem_rdata;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wins_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      waddr_q <= waddr_d;
      wins_q  <= wins_d;
    end
  end

  assign bus.fill_busy    = (state_q != IDLE);
  assign bus.fill_done    = (state_q == DONE);
  assign bus.fill_err     = (state_q == ERR);
  assign bus.mem_req      = (state_q == REQ);
  assign bus.mem_addr     = base_q;
  assign bus.cache_wr_en  = wr_en_q;
  assign bus.cache_addr   = waddr_q;
  assign bus.cache_wr_ins = wins_q;
endmodule
